// File: rtl/avmm_counter_slave_if.sv
// Avalon-MM bus bundle between the master and avmm_counter_slave.
// Signals:
//   avs_address       word address, master -> slave
//   avs_read          read strobe, master -> slave
//   avs_write         write strobe, master -> slave
//   avs_writedata     write data, master -> slave
//   avs_readdata      read data, slave -> master, one cycle after avs_read
//   avs_readdatavalid read data qualifier, slave -> master
interface avmm_counter_slave_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avmm_counter_slave.sv
// Avalon-MM slave wrapping a loadable, prescaled down-counter.
// Modes: 00 idle, 01 decrement, 10 divide-by-2, 11 reserved (idle).
// Registers: 0 LOAD(W), 1 MODE(RW), 2 COUNT(RO), 3 STATUS(bit0 ZERO, bit1 STICKY W1C),
//            4 PRESCALE(RW), 6 IRQ_MASK(RW, only with COUNTER_IRQ_EN), others read 0.
// Ports:
//   clk_clk          system clock
//   reset_reset_n    asynchronous active-low reset
//   avs              Avalon-MM slave bus (no waitrequest, read latency 1)
//   count_writedata  live counter value
//   zero_writedata   high while the counter is 0
//   irq              STICKY & IRQ_MASK (only with COUNTER_IRQ_EN defined)
// Optional feature macro: COUNTER_IRQ_EN.
module avmm_counter_slave #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  avmm_counter_slave_if.slave   avs,
  output logic [WIDTH-1:0]      count_writedata,
`ifdef COUNTER_IRQ_EN
  output logic                  irq,
`endif
  output logic                  zero_writedata
);

  localparam logic [2:0] ADDR_LOAD     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_COUNT    = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
`ifdef COUNTER_IRQ_EN
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;
`endif

  logic [WIDTH-1:0]      count_q, count_d;
  logic [1:0]            mode_q, mode_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  sticky_q, sticky_d;
  logic [31:0]           rdata;
  logic                  step_en, tick, sticky_set;
  logic [WIDTH-1:0]      step_val;
  logic                  wr_load, wr_mode, wr_status, wr_prescale;
`ifdef COUNTER_IRQ_EN
  logic                  irq_mask_q, irq_mask_d;
  logic                  wr_irq_mask;
`endif

  // Upper write-data bits are don't-care for every register.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  always_comb begin
    wr_load     = avs.avs_write && (avs.avs_address == ADDR_LOAD);
    wr_mode     = avs.avs_write && (avs.avs_address == ADDR_MODE);
    wr_status   = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    wr_prescale = avs.avs_write && (avs.avs_address == ADDR_PRESCALE);

    // Reserved mode 11 never steps; stepping also stops once the count is 0.
    step_en  = ((mode_q == 2'b01) || (mode_q == 2'b10)) && (count_q != '0);
    tick     = step_en && (pcnt_q == prescale_q);
    step_val = (mode_q == 2'b01) ? (count_q - WIDTH'(1)) : (count_q >> 1);
    // A LOAD on the same edge discards the tick entirely.
    sticky_set = tick && (step_val == '0) && !wr_load;

    count_d    = count_q;
    pcnt_d     = pcnt_q;
    mode_d     = wr_mode ? avs.avs_writedata[1:0] : mode_q;
    prescale_d = wr_prescale ? avs.avs_writedata[PRESCALE_W-1:0] : prescale_q;

    if (wr_load) begin
      count_d = avs.avs_writedata[WIDTH-1:0];
      pcnt_d  = '0;
    end else if (tick) begin
      count_d = step_val;
      pcnt_d  = '0;
    end else if (step_en) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end else begin
      pcnt_d = '0;
    end

    if (wr_load) begin
      sticky_d = 1'b0;
    end else if (sticky_set) begin
      sticky_d = 1'b1;
    end else if (wr_status && avs.avs_writedata[1]) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

`ifdef COUNTER_IRQ_EN
    wr_irq_mask = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
    irq_mask_d  = wr_irq_mask ? avs.avs_writedata[0] : irq_mask_q;
`endif

    // Read mux sees pre-write state, so a simultaneous write is not visible.
    rdata = '0;
    case (avs.avs_address)
      ADDR_MODE:     rdata = {30'd0, mode_q};
      ADDR_COUNT:    rdata = 32'(count_q);
      ADDR_STATUS:   rdata = {30'd0, sticky_q, (count_q == '0)};
      ADDR_PRESCALE: rdata = 32'(prescale_q);
`ifdef COUNTER_IRQ_EN
      ADDR_IRQ_MASK: rdata = {31'd0, irq_mask_q};
`endif
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      count_q               <= '0;
      mode_q                <= 2'b00;
      prescale_q            <= '0;
      pcnt_q                <= '0;
      sticky_q              <= 1'b0;
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
`ifdef COUNTER_IRQ_EN
      irq_mask_q            <= 1'b0;
`endif
    end else begin
      count_q               <= count_d;
      mode_q                <= mode_d;
      prescale_q            <= prescale_d;
      pcnt_q                <= pcnt_d;
      sticky_q              <= sticky_d;
      avs.avs_readdata      <= avs.avs_read ? rdata : '0;
      avs.avs_readdatavalid <= avs.avs_read;
`ifdef COUNTER_IRQ_EN
      irq_mask_q            <= irq_mask_d;
`endif
    end
  end

  assign count_writedata = count_q;
  assign zero_writedata  = (count_q == '0);
`ifdef COUNTER_IRQ_EN
  assign irq = sticky_q & irq_mask_q;
`endif

endmodule
